instruction_sequencer: RTL

Fetch-and-issue control unit for the workshop's hypothetical processor: holds the program counter, reads instruction words from a synchronous program memory, and issues each opcode (plus operand) to the downstream instruction decoder/ALU stage over a valid/ready handshake. It is the producer side of the decoder's opcode input. It also resolves `JUMP` and `JUMP_COND` by reloading the program counter from the operand field.

---
 rtl/instr_defs_pkg.sv | 41 ++++
 rtl/instruction_sequencer_program_counter.sv | 36 +++
 rtl/instruction_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instr_defs_pkg.sv
`default_nettype none
// ============================================================================
// Package     : instr_defs
// Description : Definitions shared by the sequencer, the decoder and the bench.
//               Contents:
//                 - opcode constants;
//                 - sequencer FSM state encoding;
//                 - instruction word field positions.
//               Instruction word layout is {opcode, operand}: the opcode sits
//               in the upper bits and the operand in the lower ADDR_BITS bits.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_defs;

   // Opcode values (low part of an N_BITS-wide opcode field)
   localparam int OP_LOAD      = 0;
   localparam int OP_ADD       = 1;
   localparam int OP_AND       = 2;
   localparam int OP_SUB       = 3;
   localparam int OP_INPUT     = 4;
   localparam int OP_OUTPUT    = 5;
   localparam int OP_JUMP      = 6;
   localparam int OP_JUMP_COND = 7;

   // Operand occupies the least significant bits of the instruction word;
   // the opcode starts right above it.
   localparam int OPERAND_LSB = 0;

   function automatic int opcode_lsb(input int addr_bits);
      return addr_bits;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_LATCH = 2'd2,
      ST_ISSUE = 2'd3
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/instruction_sequencer_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Wrapping program counter. When both load and inc are
//               asserted, load takes priority.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset (pc -> 0)
//               inc      - advance pc by one (modulo 2^ADDR_BITS)
//               load     - load pc from load_val
//               load_val - jump target
//               pc       - current program counter
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
   parameter int ADDR_BITS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] load_val,
   output logic [ADDR_BITS-1:0] pc
);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + ADDR_BITS'(1);   // natural wrap at 2^ADDR_BITS
      end
   end

endmodule
`default_nettype wire

// File: rtl/instruction_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Fetch-and-issue control unit. Reads instruction words from a
//               synchronous program memory and issues opcode/operand pairs
//               downstream over a valid/ready handshake. JUMP and JUMP_COND
//               are resolved by reloading the PC from the operand field.
// Ports       : clk, rst     - clock / synchronous active-high reset
//               en           - run enable (level)
//               mem_addr     - registered program memory read address
//               mem_data     - instruction word, valid one cycle after address
//               opcode_out   - issued opcode
//               operand_out  - issued operand
//               op_valid     - issued instruction valid
//               op_ready     - downstream accepts
//               cond_flag    - condition for JUMP_COND
//               pc_out       - current program counter (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer
   import instr_defs::*;
#(
   parameter int N_BITS    = 4,
   parameter int ADDR_BITS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   output logic [ADDR_BITS-1:0]        mem_addr,
   input  logic [N_BITS+ADDR_BITS-1:0] mem_data,
   output logic [N_BITS-1:0]           opcode_out,
   output logic [ADDR_BITS-1:0]        operand_out,
   output logic                        op_valid,
   input  logic                        op_ready,
   input  logic                        cond_flag,
   output logic [ADDR_BITS-1:0]        pc_out
);

   localparam int OPC_LSB = opcode_lsb(ADDR_BITS);

   seq_state_t           state;
   seq_state_t           state_next;
   logic                 handshake;
   logic                 is_jump;
   logic                 is_jump_cond;
   logic                 pc_load;
   logic                 pc_inc;
   logic [ADDR_BITS-1:0] pc;
   logic [ADDR_BITS-1:0] pc_next;

   // ------------------------------------------------------------------
   // Program counter: only changes on the handshake cycle
   // ------------------------------------------------------------------
   assign handshake    = (state == ST_ISSUE) && op_ready;
   assign is_jump      = (opcode_out == N_BITS'(OP_JUMP));
   assign is_jump_cond = (opcode_out == N_BITS'(OP_JUMP_COND));
   assign pc_load      = handshake && (is_jump || (is_jump_cond && cond_flag));
   assign pc_inc       = handshake && !pc_load;

   // Value the PC will hold after this edge. The memory address register is
   // loaded from it when entering FETCH, so a jump target is fetched with no
   // bubble and the fall-through address is never presented.
   always_comb begin
      pc_next = pc;
      if (pc_load) begin
         pc_next = operand_out;
      end else if (pc_inc) begin
         pc_next = pc + ADDR_BITS'(1);
      end
   end

   program_counter #(
      .ADDR_BITS (ADDR_BITS)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (operand_out),
      .pc       (pc)
   );

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      op_valid   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) state_next = ST_FETCH;
         end
         ST_FETCH: begin
            state_next = ST_LATCH;
         end
         ST_LATCH: begin
            state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            op_valid = 1'b1;
            if (op_ready) state_next = en ? ST_FETCH : ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Memory address and instruction register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr    <= '0;
         opcode_out  <= '0;
         operand_out <= '0;
      end else begin
         if (state_next == ST_FETCH) begin
            mem_addr <= pc_next;
         end
         // Memory data for the FETCH address is valid during LATCH; the
         // register then holds steady through the whole ISSUE phase.
         if (state == ST_LATCH) begin
            opcode_out  <= mem_data[OPC_LSB +: N_BITS];
            operand_out <= mem_data[OPERAND_LSB +: ADDR_BITS];
         end
      end
   end

   assign pc_out = pc;

endmodule
`default_nettype wire
